// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // One counter serves both the bit count and the gap count, so size it for the larger.
   function automatic int cnt_width(input int n, input int gap);
      int w;
      w = (n > 1) ? $clog2(n) : 1;
      if ((gap > 1) && ($clog2(gap) > w)) w = $clog2(gap);
      return w;
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that stops at zero; tc flags the terminal count.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign count = cnt_q;
   assign tc    = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word input, one bit per clock
// on a registered so/so_valid/so_last stream with optional inter-word gap.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int N          = 8,
   parameter bit LSB_FIRST  = 1'b0,
   parameter int GAP        = 0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] pi_data,
   input  logic         pi_valid,
   output logic         pi_ready,
   output logic         so,
   output logic         so_valid,
   output logic         so_last,
   output logic         busy
);

   localparam int           CW      = cnt_width(N, GAP);
   localparam logic [CW-1:0] LD_WORD = CW'(N - 1);
   localparam logic [CW-1:0] LD_GAP  = (GAP > 0) ? CW'(GAP - 1) : '0;

   state_e         state_q, state_d;
   logic [N-1:0]   shreg_q, shreg_d;
   logic           so_q, so_d;
   logic           so_valid_q, so_valid_d;
   logic           so_last_q, so_last_d;
   logic           cnt_load, cnt_en, cnt_tc, last_bit, accept;
   logic [CW-1:0]  cnt_val, cnt;

   piso_bit_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .count    (cnt),
      .tc       (cnt_tc)
   );

   // The counter holds the number of bits still to follow the one currently on so.
   always_comb begin
      last_bit   = (state_q == ST_SHIFT) && cnt_tc;
      pi_ready   = rst_n && ((state_q == ST_IDLE) || (last_bit && (GAP == 0)));
      accept     = pi_valid && pi_ready;
      state_d    = state_q;
      shreg_d    = shreg_q;
      so_d       = IDLE_LEVEL;
      so_valid_d = 1'b0;
      so_last_d  = 1'b0;
      cnt_load   = 1'b0;
      cnt_val    = LD_WORD;
      cnt_en     = 1'b0;
      if (accept) begin
         state_d    = ST_SHIFT;
         cnt_load   = 1'b1;
         so_valid_d = 1'b1;
         if (LSB_FIRST) begin
            so_d    = pi_data[0];
            shreg_d = pi_data >> 1;
         end else begin
            so_d    = pi_data[N-1];
            shreg_d = pi_data << 1;
         end
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (!cnt_tc) begin
                  so_valid_d = 1'b1;
                  so_last_d  = (cnt == CW'(1));
                  cnt_en     = 1'b1;
                  if (LSB_FIRST) begin
                     so_d    = shreg_q[0];
                     shreg_d = shreg_q >> 1;
                  end else begin
                     so_d    = shreg_q[N-1];
                     shreg_d = shreg_q << 1;
                  end
               end else if (GAP > 0) begin
                  state_d  = ST_GAP;
                  cnt_load = 1'b1;
                  cnt_val  = LD_GAP;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_GAP: begin
               if (cnt_tc) state_d = ST_IDLE;
               else        cnt_en  = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         so_q       <= IDLE_LEVEL;
         so_valid_q <= 1'b0;
         so_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         so_q       <= so_d;
         so_valid_q <= so_valid_d;
         so_last_q  <= so_last_d;
      end
   end

   assign so       = so_q;
   assign so_valid = so_valid_q;
   assign so_last  = so_last_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three serializer configurations (MSB-first/no gap, gap of 2,
// LSB-first with idle level 1) driven with hand-chosen words.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pd [3];
   logic       pv [3];
   logic       rdy [3];
   logic       so [3];
   logic       sv [3];
   logic       sl [3];
   logic       bz [3];
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   piso_serializer #(.N(8), .LSB_FIRST(1'b0), .GAP(0), .IDLE_LEVEL(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .pi_data(pd[0]), .pi_valid(pv[0]), .pi_ready(rdy[0]),
      .so(so[0]), .so_valid(sv[0]), .so_last(sl[0]), .busy(bz[0]));

   piso_serializer #(.N(8), .LSB_FIRST(1'b0), .GAP(2), .IDLE_LEVEL(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .pi_data(pd[1]), .pi_valid(pv[1]), .pi_ready(rdy[1]),
      .so(so[1]), .so_valid(sv[1]), .so_last(sl[1]), .busy(bz[1]));

   piso_serializer #(.N(8), .LSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .pi_data(pd[2]), .pi_valid(pv[2]), .pi_ready(rdy[2]),
      .so(so[2]), .so_valid(sv[2]), .so_last(sl[2]), .busy(bz[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input int d, input string tag, input logic lvl, input logic bsy);
      chk($sformatf("%s d%0d so", tag, d), 32'(so[d]), 32'(lvl));
      chk($sformatf("%s d%0d so_valid", tag, d), 32'(sv[d]), 32'(1'b0));
      chk($sformatf("%s d%0d so_last", tag, d), 32'(sl[d]), 32'(1'b0));
      chk($sformatf("%s d%0d busy", tag, d), 32'(bz[d]), 32'(bsy));
   endtask

   // Present a word while the DUT is ready and take the accepting edge.
   task automatic send(input int d, input logic [7:0] w);
      pd[d] = w;
      pv[d] = 1'b1;
      chk($sformatf("send d%0d ready", d), 32'(rdy[d]), 32'(1'b1));
      tick();
   endtask

   // Check the 8 bit-cycles following an accept; expected bits come from the word itself.
   task automatic check_word(input int d, input logic [7:0] w, input bit lsb,
                             input bit keep, input bit rdy_last);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("w%0h d%0d bit%0d", w, d, i), 32'(so[d]), 32'(lsb ? w[i] : w[7-i]));
         chk($sformatf("w%0h d%0d valid%0d", w, d, i), 32'(sv[d]), 32'(1'b1));
         chk($sformatf("w%0h d%0d last%0d", w, d, i), 32'(sl[d]), 32'(i == 7));
         chk($sformatf("w%0h d%0d busy%0d", w, d, i), 32'(bz[d]), 32'(1'b1));
         chk($sformatf("w%0h d%0d ready%0d", w, d, i), 32'(rdy[d]), 32'((i == 7) ? rdy_last : 1'b0));
         if ((i == 0) && !keep) pv[d] = 1'b0;
         tick();
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         pd[d] = 8'h00;
         pv[d] = 1'b0;
      end
      rst_n = 1'b0;
      tick();
      tick();
      chk_idle(0, "rst", 1'b0, 1'b0);
      chk_idle(2, "rst", 1'b1, 1'b0);
      chk("rst ready0", 32'(rdy[0]), 32'(1'b0));
      rst_n = 1'b1;
      tick();

      // Single MSB-first word.
      send(0, 8'hA5);
      check_word(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      chk_idle(0, "after A5", 1'b0, 1'b0);
      tick();

      // Back-to-back words, second held valid from the start.
      send(0, 8'hA5);
      pd[0] = 8'h3C;
      check_word(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      check_word(0, 8'h3C, 1'b0, 1'b0, 1'b1);
      chk_idle(0, "after 3C", 1'b0, 1'b0);

      // GAP=2: two gap cycles, then an idle cycle where the next word is taken.
      send(1, 8'hC3);
      pd[1] = 8'h5A;
      check_word(1, 8'hC3, 1'b0, 1'b1, 1'b0);
      for (int g = 0; g < 2; g++) begin
         chk_idle(1, $sformatf("gap%0d", g), 1'b0, 1'b1);
         chk($sformatf("gap%0d ready", g), 32'(rdy[1]), 32'(1'b0));
         tick();
      end
      chk_idle(1, "post gap", 1'b0, 1'b0);
      chk("post gap ready", 32'(rdy[1]), 32'(1'b1));
      tick();
      check_word(1, 8'h5A, 1'b0, 1'b0, 1'b0);
      chk_idle(1, "gap after 5A", 1'b0, 1'b1);

      // LSB-first with idle level 1.
      send(2, 8'h01);
      check_word(2, 8'h01, 1'b1, 1'b0, 1'b1);
      chk_idle(2, "after 01", 1'b1, 1'b0);

      // Upstream noise while a word is in flight.
      send(0, 8'h96);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("noise bit%0d", i), 32'(so[0]), 32'((8'h96 >> (7 - i)) & 8'h01));
         chk($sformatf("noise valid%0d", i), 32'(sv[0]), 32'(1'b1));
         pv[0] = (i < 7) ? i[0] : 1'b0;
         pd[0] = 8'(i * 37 + 1);
         tick();
      end
      chk_idle(0, "after noise", 1'b0, 1'b0);
      tick();
      chk_idle(0, "after noise+1", 1'b0, 1'b0);

      // Reset in mid-word, then a clean word.
      send(0, 8'hFF);
      pv[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ff bit%0d", i), 32'(so[0]), 32'(1'b1));
         chk($sformatf("ff valid%0d", i), 32'(sv[0]), 32'(1'b1));
         if (i < 3) tick();
      end
      rst_n = 1'b0;
      #1;
      chk_idle(0, "midrst", 1'b0, 1'b0);
      chk("midrst ready", 32'(rdy[0]), 32'(1'b0));
      tick();
      chk_idle(0, "midrst+1", 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      chk_idle(0, "rel", 1'b0, 1'b0);
      send(0, 8'h81);
      check_word(0, 8'h81, 1'b0, 1'b0, 1'b1);
      chk_idle(0, "after 81", 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
